uart_tx_sched: RTL and testbench

- Transmit-side controller for the UART transmitter (`send`/`dout`/`busy` handshake).
- Buffers bytes written by the bus/CPU side in a small FIFO and sequences them into the transmitter one at a time.
- Issues single-cycle send strobes, tracks transmitter busy, and reports completion and error status.
- Sits between the peripheral register interface and the `uart_tx` instance.

---
 rtl/uart_tx_sched_if.sv | 41 ++++
 rtl/uart_tx_sched.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Groups the scheduler's bus-side and transmitter-side signals.
//   slave  : the scheduler (uart_tx_sched)
//   master : everything around it, i.e. the register/CPU side plus the
//            uart_tx instance that returns uart_busy
// Signals:
//   en, flush, err_clr, wr_en, wr_data  control and write port from the bus
//   full, empty, count                  FIFO status back to the bus
//   overflow, ack_err, tx_done          status/completion back to the bus
//   uart_send, uart_dout                strobe and byte to the transmitter
//   uart_busy                           busy flag from the transmitter
interface uart_tx_sched_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          flush;
  logic          err_clr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          uart_send;
  logic [7:0]    uart_dout;
  logic          uart_busy;
  logic          tx_done;
  logic          overflow;
  logic          ack_err;

  modport master (
    output en, flush, err_clr, wr_en, wr_data, uart_busy,
    input  full, empty, count, uart_send, uart_dout, tx_done, overflow, ack_err
  );

  modport slave (
    input  en, flush, err_clr, wr_en, wr_data, uart_busy,
    output full, empty, count, uart_send, uart_dout, tx_done, overflow, ack_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Transmit-side scheduler for a UART transmitter. Bytes written from the bus
// are queued in a DEPTH-entry circular FIFO and handed to the transmitter one
// at a time with a single-cycle send strobe. The scheduler then waits for the
// transmitter's busy flag to rise and fall, pulses tx_done, and goes back to
// IDLE. A busy flag that never rises within ACK_TIMEOUT cycles sets the sticky
// ack_err flag; a write into a full FIFO sets the sticky overflow flag.
// Ports:
//   clk    bus clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_sched_if.slave (write port, control, FIFO status, sticky
//          flags, tx_done, and the uart_send/uart_dout/uart_busy handshake)
module uart_tx_sched #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_sched_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          send_q;
  logic [7:0]    dout_q;
  logic          done_q;
  logic          ovf_q;
  logic          ack_err_q;
  logic [TW-1:0] to_cnt;
  logic          push;
  logic          pop;
  logic          drop;

  // A flush swallows any same-cycle write silently and blocks a pop, so the
  // FIFO is guaranteed empty on the following cycle. A write seen while full
  // is dropped even if a pop frees a slot on that same edge.
  always_comb begin
    push      = bus.wr_en && !full_q && !bus.flush;
    drop      = bus.wr_en &&  full_q && !bus.flush;
    pop       = (state == IDLE) && bus.en && !empty_q && !bus.uart_busy && !bus.flush;
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count_q <= count_nxt;
        full_q  <= (count_nxt == CW'(DEPTH));
        empty_q <= (count_nxt == '0);
      end
      // A new drop outranks a same-cycle clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Launch FSM. uart_send is high only while in SEND; uart_dout is loaded on
  // the pop and left untouched until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      send_q    <= 1'b0;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      to_cnt    <= '0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.err_clr) begin
        ack_err_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            dout_q <= mem[rd_ptr];
            send_q <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.uart_busy) begin
            state <= WAIT_LO;
          end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            // This would be the ACK_TIMEOUT-th cycle without busy.
            ack_err_q <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        WAIT_LO: begin
          if (!bus.uart_busy) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.uart_send = send_q;
  assign bus.uart_dout = dout_q;
  assign bus.tx_done   = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.ack_err   = ack_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Directed bench for uart_tx_sched: a per-cycle vector table for the FIFO
// bookkeeping with launches disabled, plus hand-written sequences for the
// multi-cycle transmit handshake, flush, ack timeout, reset and the
// simultaneous push/pop corner cases. A small transmitter model drives
// uart_busy high for 10 cycles starting the edge after it sees a strobe.
module tb_uart_tx_sched;
  localparam int DEPTH       = 8;
  localparam int ACK_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_sched #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Transmitter model; tx_dead makes it ignore strobes entirely.
  logic tx_busy = 1'b0;
  int   bcnt    = 0;
  bit   tx_dead = 1'b0;
  assign bus.uart_busy = tx_busy;

  always @(posedge clk) begin
    if (!tx_dead && bus.uart_send === 1'b1) begin
      tx_busy <= 1'b1;
      bcnt    <= 10;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  // Monitor: strobe/done counts, bytes launched, back-to-back strobes and
  // any change of uart_dout that is not accompanied by a strobe.
  int         strobe_cnt  = 0;
  int         done_cnt    = 0;
  int         b2b_cnt     = 0;
  int         dout_glitch = 0;
  logic       prev_send   = 1'b0;
  logic [7:0] held        = 8'h00;
  logic [7:0] sent_q [$];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_send <= 1'b0;
      held      <= 8'h00;
    end else begin
      if (bus.uart_send === 1'b1) begin
        strobe_cnt <= strobe_cnt + 1;
        sent_q.push_back(bus.uart_dout);
        held <= bus.uart_dout;
        if (prev_send) b2b_cnt <= b2b_cnt + 1;
      end else if (bus.uart_dout !== held) begin
        dout_glitch <= dout_glitch + 1;
      end
      if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
      prev_send <= bus.uart_send;
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       err_clr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.en      = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (bus.uart_busy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.uart_busy), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (bus.tx_done === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;

    // Vector table: en=0 throughout, one record per clock edge.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 8'(i), 1'b0, 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b0};
    end
    vecs[8]  = '{1'b1, 8'h08, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};  // dropped
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};  // clear
    vecs[10] = '{1'b1, 8'h09, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1};  // set wins
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};  // clear

    // Reset
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst empty",    32'(bus.empty),     1);
    check("rst full",     32'(bus.full),      0);
    check("rst count",    32'(bus.count),     0);
    check("rst send",     32'(bus.uart_send), 0);
    check("rst dout",     32'(bus.uart_dout), 0);
    check("rst tx_done",  32'(bus.tx_done),   0);
    check("rst overflow", 32'(bus.overflow),  0);
    check("rst ack_err",  32'(bus.ack_err),   0);
    rst_n = 1'b1;
    tick();

    // 1: single byte, exact latency
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick();                                    // edge N
    bus.wr_en = 1'b0;
    check("t1 empty after write", 32'(bus.empty),     0);
    check("t1 count after write", 32'(bus.count),     1);
    check("t1 send at N",         32'(bus.uart_send), 0);
    tick();                                    // edge N+1: pop
    check("t1 send at N+1",       32'(bus.uart_send), 1);
    check("t1 dout at N+1",       32'(bus.uart_dout), 32'hA5);
    check("t1 empty after pop",   32'(bus.empty),     1);
    tick();                                    // edge N+2
    check("t1 send at N+2",       32'(bus.uart_send), 0);
    repeat (10) tick();                        // edge N+12: busy falls
    check("t1 busy low",          32'(bus.uart_busy), 0);
    check("t1 no early done",     32'(bus.tx_done),   0);
    check("t1 dout held",         32'(bus.uart_dout), 32'hA5);
    tick();                                    // edge N+13
    check("t1 tx_done pulse",     32'(bus.tx_done),   1);
    tick();
    check("t1 tx_done one cycle", 32'(bus.tx_done),   0);
    check("t1 strobes",           32'(strobe_cnt),    1);
    check("t1 dones",             32'(done_cnt),      1);

    // 2: fill/overflow table with en=0, then drain in order
    bus.en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.flush   = vecs[i].flush;
      bus.err_clr = vecs[i].err_clr;
      tick();
      check($sformatf("vec%0d count", i), 32'(bus.count),     32'(vecs[i].count));
      check($sformatf("vec%0d full", i),  32'(bus.full),      32'(vecs[i].full));
      check($sformatf("vec%0d empty", i), 32'(bus.empty),     32'(vecs[i].empty));
      check($sformatf("vec%0d ovf", i),   32'(bus.overflow),  32'(vecs[i].ovf));
      check($sformatf("vec%0d send", i),  32'(bus.uart_send), 0);
    end
    drive_idle();
    sent_q.delete();
    d0 = done_cnt;
    s0 = strobe_cnt;
    bus.en = 1'b1;
    begin
      int n = 0;
      while (done_cnt < d0 + 8 && n < 250) begin
        tick();
        n++;
      end
    end
    repeat (20) tick();
    check("t2 dones",   32'(done_cnt - d0),   8);
    check("t2 strobes", 32'(strobe_cnt - s0), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2 byte%0d", k),
            (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hDEAD, 32'(k));
    end
    check("t2 empty", 32'(bus.empty), 1);

    // 3: flush during WAIT_LO
    bus.en = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("t3 count 3", 32'(bus.count), 3);
    sent_q.delete();
    s0 = strobe_cnt;
    d0 = done_cnt;
    bus.en = 1'b1;
    wait_busy("t3 busy rise", 30);
    tick();                                    // scheduler now in WAIT_LO
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h44;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check("t3 count after flush", 32'(bus.count),    0);
    check("t3 empty after flush", 32'(bus.empty),    1);
    check("t3 no ovf on flush",   32'(bus.overflow), 0);
    wait_done("t3 in-flight done", 30);
    repeat (30) tick();
    check("t3 strobes", 32'(strobe_cnt - s0), 1);
    check("t3 dones",   32'(done_cnt - d0),   1);
    check("t3 byte",    (sent_q.size() > 0) ? 32'(sent_q[0]) : 32'hDEAD, 32'h11);

    // 4: busy never rises
    tx_dead = 1'b1;
    s0 = strobe_cnt;
    d0 = done_cnt;
    push_byte(8'h5A);                          // edge N
    tick();                                    // edge N+1
    check("t4 send",       32'(bus.uart_send), 1);
    check("t4 dout",       32'(bus.uart_dout), 32'h5A);
    repeat (4) tick();                         // edge N+5
    check("t4 ack_err early", 32'(bus.ack_err), 0);
    tick();                                    // edge N+6
    check("t4 ack_err set",   32'(bus.ack_err), 1);
    repeat (5) tick();
    check("t4 ack_err sticky", 32'(bus.ack_err),       1);
    check("t4 strobes",        32'(strobe_cnt - s0),   1);
    check("t4 no done",        32'(done_cnt - d0),     0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4 ack_err cleared", 32'(bus.ack_err), 0);
    tx_dead = 1'b0;

    // 5: reset during WAIT_LO with two bytes queued
    bus.en = 1'b0;
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    bus.en = 1'b1;
    wait_busy("t5 busy rise", 30);
    tick();
    check("t5 count before rst", 32'(bus.count), 2);
    rst_n = 1'b0;
    #1;
    check("t5 count",    32'(bus.count),     0);
    check("t5 empty",    32'(bus.empty),     1);
    check("t5 full",     32'(bus.full),      0);
    check("t5 send",     32'(bus.uart_send), 0);
    check("t5 dout",     32'(bus.uart_dout), 0);
    check("t5 tx_done",  32'(bus.tx_done),   0);
    check("t5 overflow", 32'(bus.overflow),  0);
    check("t5 ack_err",  32'(bus.ack_err),   0);
    s0 = strobe_cnt;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("t5 no strobe after rst", 32'(strobe_cnt - s0), 0);
    check("t5 empty after rst",     32'(bus.empty),       1);

    // 6: simultaneous push and pop
    bus.en = 1'b0;
    for (int k = 0; k < 7; k++) push_byte(8'(8'h70 + k));
    check("t6 count 7", 32'(bus.count), 7);
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    tick();
    bus.en    = 1'b0;
    bus.wr_en = 1'b0;
    check("t6 push+pop count", 32'(bus.count),     7);
    check("t6 push+pop send",  32'(bus.uart_send), 1);
    check("t6 push+pop dout",  32'(bus.uart_dout), 32'h70);
    push_byte(8'h78);
    check("t6 full",       32'(bus.full),  1);
    check("t6 count 8",    32'(bus.count), 8);
    wait_done("t6 first byte done", 30);
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h79;
    tick();
    bus.en    = 1'b0;
    bus.wr_en = 1'b0;
    check("t6 full pop send",  32'(bus.uart_send), 1);
    check("t6 full pop dout",  32'(bus.uart_dout), 32'h71);
    check("t6 full pop count", 32'(bus.count),     7);
    check("t6 full pop full",  32'(bus.full),      0);
    check("t6 full pop ovf",   32'(bus.overflow),  1);
    wait_done("t6 second byte done", 30);
    tick();

    check("no back-to-back strobes", 32'(b2b_cnt),     0);
    check("dout stable between pops", 32'(dout_glitch), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
